// File: rtl/scoreboard_pkg.sv
// Shared types and constants for the scoreboard game clock: FSM states,
// BCD digit type and the minutes-to-BCD conversion used for load values.
package scoreboard_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RUN       = 3'd1,
        ST_PAUSE     = 3'd2,
        ST_EXPIRED   = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t SEC_TENS_MAX = 4'd5;
    localparam bcd_digit_t DIGIT_MAX    = 4'd9;

    // Binary minutes (0..99) to two packed BCD digits, tens in [7:4].
    function automatic logic [7:0] min_to_bcd(input int unsigned minutes);
        bcd_digit_t tens_s;
        bcd_digit_t ones_s;
        tens_s = 4'(minutes / 32'd10);
        ones_s = 4'(minutes % 32'd10);
        return {tens_s, ones_s};
    endfunction

endpackage

// File: rtl/bcd_mmss_down_counter.sv
// MM:SS down-counter held as four BCD digits with a borrow chain.
// Saturates at 00:00; load has priority over decrement.
module bcd_mmss_down_counter
    import scoreboard_pkg::*;
#(
    parameter logic [15:0] RESET_VAL = 16'h1500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        dec,
    output logic [15:0] mmss,
    output logic        zero,
    output logic        last
);

    bcd_digit_t min_tens_r, min_ones_r, sec_tens_r, sec_ones_r;
    bcd_digit_t min_tens_s, min_ones_s, sec_tens_s, sec_ones_s;

    assign mmss = {min_tens_r, min_ones_r, sec_tens_r, sec_ones_r};
    assign zero = (mmss == 16'h0000);
    assign last = (mmss == 16'h0001);

    // Next-digit arithmetic: ones of seconds borrow into tens, tens into minutes.
    always_comb begin
        min_tens_s = min_tens_r;
        min_ones_s = min_ones_r;
        sec_tens_s = sec_tens_r;
        sec_ones_s = sec_ones_r;
        if (load) begin
            {min_tens_s, min_ones_s, sec_tens_s, sec_ones_s} = load_val;
        end else if (dec && !zero) begin
            if (sec_ones_r != 4'd0) begin
                sec_ones_s = sec_ones_r - 4'd1;
            end else begin
                sec_ones_s = DIGIT_MAX;
                if (sec_tens_r != 4'd0) begin
                    sec_tens_s = sec_tens_r - 4'd1;
                end else begin
                    sec_tens_s = SEC_TENS_MAX;
                    if (min_ones_r != 4'd0) begin
                        min_ones_s = min_ones_r - 4'd1;
                    end else begin
                        // Non-zero count guarantees min_tens_r > 0 here.
                        min_ones_s = DIGIT_MAX;
                        min_tens_s = min_tens_r - 4'd1;
                    end
                end
            end
        end else begin
            min_tens_s = min_tens_r;
        end
    end

    // Digit registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {min_tens_r, min_ones_r, sec_tens_r, sec_ones_r} <= RESET_VAL;
        end else begin
            min_tens_r <= min_tens_s;
            min_ones_r <= min_ones_s;
            sec_tens_r <= sec_tens_s;
            sec_ones_r <= sec_ones_s;
        end
    end

endmodule

// File: rtl/game_clock_countdown.sv
// Game clock: synchronizes the timebase square wave, counts MM:SS down in BCD,
// tracks quarters and run/pause/expiry. Optional horn via SCOREBOARD_HORN_EN.
module game_clock_countdown
    import scoreboard_pkg::*;
#(
    parameter int START_MIN    = 15,
    parameter int NUM_QUARTERS = 4
`ifdef SCOREBOARD_HORN_EN
    ,
    parameter int HORN_SECONDS = 3
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_toggle,
    input  logic       start,
    input  logic       stop,
    input  logic       next_period,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic [2:0] quarter,
    output logic       running,
    output logic       expired,
    output logic       game_over
`ifdef SCOREBOARD_HORN_EN
    ,
    output logic       horn
`endif
);

    localparam logic [15:0] RELOAD_VAL = {min_to_bcd(START_MIN), 8'h00};

    logic   sync1_r, sync2_r, delay_r;
    logic   tick_s;
    state_t state_r, next_state_s;
    logic   load_s, dec_s, quarter_inc_s;
    logic   zero_s, last_s;
    logic   [15:0] mmss_s;
    logic   [2:0]  quarter_r;
    logic   running_r, expired_r, game_over_r;
    logic   enter_expired_s;

    // Two-flop synchronizer plus delay flop for rising-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            delay_r <= 1'b0;
        end else begin
            sync1_r <= tick_toggle;
            sync2_r <= sync1_r;
            delay_r <= sync2_r;
        end
    end

    assign tick_s = sync2_r & ~delay_r;

    bcd_mmss_down_counter #(
        .RESET_VAL(RELOAD_VAL)
    ) u_counter (
        .clk     (clk),
        .rst     (rst),
        .load    (load_s),
        .load_val(RELOAD_VAL),
        .dec     (dec_s),
        .mmss    (mmss_s),
        .zero    (zero_s),
        .last    (last_s)
    );

    // Next-state and datapath strobes; stop always beats start and tick.
    always_comb begin
        next_state_s  = state_r;
        load_s        = 1'b0;
        dec_s         = 1'b0;
        quarter_inc_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start && !stop) next_state_s = ST_RUN;
                else                next_state_s = ST_IDLE;
            end
            ST_RUN: begin
                if (stop) begin
                    next_state_s = ST_PAUSE;
                end else if (tick_s) begin
                    dec_s = 1'b1;
                    if (last_s || zero_s) next_state_s = ST_EXPIRED;
                    else                  next_state_s = ST_RUN;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_PAUSE: begin
                if (start && !stop) next_state_s = ST_RUN;
                else                next_state_s = ST_PAUSE;
            end
            ST_EXPIRED: begin
                if (next_period) begin
                    if (quarter_r < 3'(NUM_QUARTERS)) begin
                        next_state_s  = ST_IDLE;
                        load_s        = 1'b1;
                        quarter_inc_s = 1'b1;
                    end else begin
                        next_state_s = ST_GAME_OVER;
                    end
                end else begin
                    next_state_s = ST_EXPIRED;
                end
            end
            ST_GAME_OVER: next_state_s = ST_GAME_OVER;
            default:      next_state_s = ST_IDLE;
        endcase
    end

    assign enter_expired_s = (state_r == ST_RUN) && (next_state_s == ST_EXPIRED);

    // State, quarter and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            quarter_r   <= 3'd1;
            running_r   <= 1'b0;
            expired_r   <= 1'b0;
            game_over_r <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            quarter_r   <= quarter_inc_s ? quarter_r + 3'd1 : quarter_r;
            running_r   <= (next_state_s == ST_RUN);
            expired_r   <= enter_expired_s;
            game_over_r <= (next_state_s == ST_GAME_OVER);
        end
    end

`ifdef SCOREBOARD_HORN_EN
    logic       horn_r;
    logic [3:0] horn_cnt_r;

    // Horn sounds from expiry for HORN_SECONDS ticks; next_period silences it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            horn_r     <= 1'b0;
            horn_cnt_r <= 4'd0;
        end else if (enter_expired_s) begin
            horn_r     <= 1'b1;
            horn_cnt_r <= 4'(HORN_SECONDS);
        end else if ((state_r == ST_EXPIRED) && next_period) begin
            horn_r     <= 1'b0;
            horn_cnt_r <= 4'd0;
        end else if ((state_r == ST_EXPIRED) && tick_s && (horn_cnt_r != 4'd0)) begin
            horn_r     <= (horn_cnt_r != 4'd1);
            horn_cnt_r <= horn_cnt_r - 4'd1;
        end else begin
            horn_r     <= horn_r;
            horn_cnt_r <= horn_cnt_r;
        end
    end

    assign horn = horn_r;
`endif

    assign min_bcd   = mmss_s[15:8];
    assign sec_bcd   = mmss_s[7:0];
    assign quarter   = quarter_r;
    assign running   = running_r;
    assign expired   = expired_r;
    assign game_over = game_over_r;

endmodule

// File: tb/tb_game_clock_countdown.sv
// Directed bench for game_clock_countdown (START_MIN=1, NUM_QUARTERS=2) with
// a queue scoreboard of expected values; horn checks when SCOREBOARD_HORN_EN.
module tb_game_clock_countdown;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_toggle;
    logic       start, stop, next_period;
    logic [7:0] min_bcd, sec_bcd;
    logic [2:0] quarter;
    logic       running, expired, game_over;
`ifdef SCOREBOARD_HORN_EN
    logic       horn;
`endif

    int passed = 0;
    int total  = 0;
    string       tag_q[$];
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    game_clock_countdown #(
        .START_MIN   (1),
        .NUM_QUARTERS(2)
`ifdef SCOREBOARD_HORN_EN
        ,
        .HORN_SECONDS(3)
`endif
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick_toggle(tick_toggle),
        .start      (start),
        .stop       (stop),
        .next_period(next_period),
        .min_bcd    (min_bcd),
        .sec_bcd    (sec_bcd),
        .quarter    (quarter),
        .running    (running),
        .expired    (expired),
        .game_over  (game_over)
`ifdef SCOREBOARD_HORN_EN
        ,
        .horn       (horn)
`endif
    );

    task automatic push(input string tag, input logic [15:0] exp);
        tag_q.push_back(tag);
        exp_q.push_back(exp);
    endtask

    task automatic pop_chk(input logic [15:0] obs);
        string       tag;
        logic [15:0] exp;
        total++;
        if (exp_q.size() == 0) begin
            $error("FAIL scoreboard_empty observed=%h expected=none", obs);
        end else begin
            tag = tag_q.pop_front();
            exp = exp_q.pop_front();
            assert (obs === exp) passed++;
            else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] t_now();
        return {min_bcd, sec_bcd};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        tick_toggle = 1'b1;
        repeat (3) step();
        tick_toggle = 1'b0;
        repeat (3) step();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) do_tick();
    endtask

    task automatic pulse(input logic s_go, input logic s_stop, input logic s_next);
        start = s_go;
        stop = s_stop;
        next_period = s_next;
        step();
        start = 1'b0;
        stop = 1'b0;
        next_period = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        tick_toggle = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        next_period = 1'b0;
        repeat (3) step();

        // Reset state
        push("rst_time", 16'h0100);
        push("rst_quarter", 16'd1);
        push("rst_running", 16'd0);
        push("rst_expired", 16'd0);
        push("rst_game_over", 16'd0);
        pop_chk(t_now());
        pop_chk(16'(quarter));
        pop_chk(16'(running));
        pop_chk(16'(expired));
        pop_chk(16'(game_over));
`ifdef SCOREBOARD_HORN_EN
        push("rst_horn", 16'd0);
        pop_chk(16'(horn));
`endif
        rst = 1'b0;
        step();

        // Start, then one tick with latency check
        push("start_running", 16'd1);
        pulse(1'b1, 1'b0, 1'b0);
        pop_chk(16'(running));
        push("lat_2edges", 16'h0100);
        push("lat_3edges", 16'h0059);
        tick_toggle = 1'b1;
        step();
        step();
        pop_chk(t_now());
        step();
        pop_chk(t_now());
        tick_toggle = 1'b0;
        repeat (3) step();

        // Count down to expiry
        push("t_0001", 16'h0001);
        ticks(58);
        pop_chk(t_now());
        push("exp_time", 16'h0000);
        push("exp_pulse", 16'd1);
        push("exp_running", 16'd0);
        tick_toggle = 1'b1;
        repeat (3) step();
        pop_chk(t_now());
        pop_chk(16'(expired));
        pop_chk(16'(running));
`ifdef SCOREBOARD_HORN_EN
        push("horn_rise", 16'd1);
        pop_chk(16'(horn));
`endif
        push("exp_pulse_end", 16'd0);
        step();
        pop_chk(16'(expired));
        tick_toggle = 1'b0;
        repeat (3) step();
`ifdef SCOREBOARD_HORN_EN
        push("horn_t1", 16'd1);
        do_tick();
        pop_chk(16'(horn));
        push("horn_t2", 16'd1);
        do_tick();
        pop_chk(16'(horn));
        push("horn_t3", 16'd0);
        do_tick();
        pop_chk(16'(horn));
`else
        ticks(3);
`endif
        push("hold_0000", 16'h0000);
        pop_chk(t_now());

        // Next period reloads and advances quarter; IDLE ignores ticks
        push("np_quarter", 16'd2);
        push("np_time", 16'h0100);
        pulse(1'b0, 1'b0, 1'b1);
        pop_chk(16'(quarter));
        pop_chk(t_now());
        push("idle_tick", 16'h0100);
        do_tick();
        pop_chk(t_now());

        // Pause holds time; next_period in RUN has no effect
        pulse(1'b1, 1'b0, 1'b0);
        push("t_0055", 16'h0055);
        ticks(5);
        pop_chk(t_now());
        push("np_in_run", 16'd2);
        pulse(1'b0, 1'b0, 1'b1);
        pop_chk(16'(quarter));
        push("stop_running", 16'd0);
        pulse(1'b0, 1'b1, 1'b0);
        pop_chk(16'(running));
        push("pause_hold", 16'h0055);
        ticks(5);
        pop_chk(t_now());
        push("resume_running", 16'd1);
        pulse(1'b1, 1'b0, 1'b0);
        pop_chk(16'(running));
        push("t_0054", 16'h0054);
        do_tick();
        pop_chk(t_now());

        // Stop coincident with tick discards the tick
        push("t_0040", 16'h0040);
        ticks(14);
        pop_chk(t_now());
        push("stop_tick_time", 16'h0040);
        push("stop_tick_running", 16'd0);
        tick_toggle = 1'b1;
        step();
        step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        pop_chk(t_now());
        pop_chk(16'(running));
        tick_toggle = 1'b0;
        repeat (3) step();
        push("start_stop_pause", 16'd0);
        pulse(1'b1, 1'b1, 1'b0);
        pop_chk(16'(running));
        push("still_paused", 16'h0040);
        do_tick();
        pop_chk(t_now());

        // Asynchronous reset mid-count
        pulse(1'b1, 1'b0, 1'b0);
        push("t_0017", 16'h0017);
        ticks(23);
        pop_chk(t_now());
        push("arst_time", 16'h0100);
        push("arst_quarter", 16'd1);
        push("arst_running", 16'd0);
        #2;
        rst = 1'b1;
        #1;
        pop_chk(t_now());
        pop_chk(16'(quarter));
        pop_chk(16'(running));
        step();
        rst = 1'b0;
        step();

        // Two quarters to game over
        pulse(1'b1, 1'b0, 1'b0);
        push("q1_end", 16'h0000);
        ticks(60);
        pop_chk(t_now());
        push("q2_quarter", 16'd2);
        push("q2_time", 16'h0100);
        pulse(1'b0, 1'b0, 1'b1);
        pop_chk(16'(quarter));
        pop_chk(t_now());
        pulse(1'b1, 1'b0, 1'b0);
        push("q2_end", 16'h0000);
        ticks(60);
        pop_chk(t_now());
`ifdef SCOREBOARD_HORN_EN
        push("horn_q2", 16'd1);
        pop_chk(16'(horn));
`endif
        push("go_level", 16'd1);
        push("go_quarter", 16'd2);
        pulse(1'b0, 1'b0, 1'b1);
        pop_chk(16'(game_over));
        pop_chk(16'(quarter));
`ifdef SCOREBOARD_HORN_EN
        push("horn_np_drop", 16'd0);
        pop_chk(16'(horn));
`endif
        push("go_start_ignored", 16'd0);
        push("go_hold", 16'd1);
        pulse(1'b1, 1'b0, 1'b0);
        pop_chk(16'(running));
        pop_chk(16'(game_over));
        push("go_tick_time", 16'h0000);
        do_tick();
        pop_chk(t_now());
        push("go_np_quarter", 16'd2);
        pulse(1'b0, 1'b0, 1'b1);
        pop_chk(16'(quarter));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
